// File: rtl/fp_div_seq_if.sv
// Handshake and operand/result bundle between the FPU issue logic (master) and fp_div_seq (slave).
interface fp_div_seq_if #(
    parameter int unsigned W = 32
);
    logic         act;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [2:0]   round_m;
    logic [W-1:0] out;
    logic         busy;
    logic         done;
    logic         ov;
    logic         un;
    logic         inv;
    logic         div_zero;
    logic         inexact;

    modport master (
        output act, in1, in2, round_m,
        input  out, busy, done, ov, un, inv, div_zero, inexact
    );
    modport slave (
        input  act, in1, in2, round_m,
        output out, busy, done, ov, un, inv, div_zero, inexact
    );
endinterface

// File: rtl/fp_div_seq.sv
// Multi-cycle IEEE-754 divider, radix-2 restoring, one quotient bit per cycle.
// Optional FP_DIV_SUBNORM_EN: full subnormal support (default build flushes subnormals to zero).
module fp_div_seq #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned W     = EXP_W + MAN_W + 1
) (
    input logic         clk,
    input logic         rst,
    fp_div_seq_if.slave bus
);
    localparam int unsigned SW   = MAN_W + 1;
    localparam int unsigned RW   = MAN_W + 2;
    localparam int unsigned QW   = MAN_W + 3;
    localparam int unsigned XW   = EXP_W + 2;
    localparam int unsigned CW   = $clog2(MAN_W + 4);
    localparam int unsigned LAST = MAN_W + 3;

    localparam logic [XW-1:0]        BIAS     = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] EXP_ZERO = '0;

    localparam logic [2:0] RNE = 3'd0;
    localparam logic [2:0] RZ  = 3'd1;
    localparam logic [2:0] RD  = 3'd2;
    localparam logic [2:0] RU  = 3'd3;
    localparam logic [2:0] RNA = 3'd4;

    typedef enum logic [1:0] {IDLE, PRE, DIV, RND} state_e;

    state_e                 state_q;
    logic [W-1:0]           a_op_q, b_op_q, spec_res_q, out_q;
    logic [2:0]             rm_q;
    logic                   sign_q, sticky_q, spec_q, spec_inv_q, spec_dz_q;
    logic signed [XW-1:0]   exp_q;
    logic [RW-1:0]          rem_q;
    logic [SW-1:0]          b_q;
    logic [QW-1:0]          quo_q;
    logic [CW-1:0]          cnt_q;
    logic                   busy_q, done_q, ov_q, un_q, inv_q, dz_q, nx_q;

    // Unpacks a finite operand into a biased exponent and a normalised significand.
    function automatic void norm(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f,
                                 output logic [XW-1:0] ex, output logic [SW-1:0] sig);
`ifdef FP_DIV_SUBNORM_EN
        int unsigned sh;
`endif
        ex  = XW'(e);
        sig = {1'b1, f};
`ifdef FP_DIV_SUBNORM_EN
        if (e == '0) begin
            sh = 1;
            for (int i = 0; i < int'(MAN_W); i++) begin
                if (f[i]) sh = MAN_W - i;
            end
            sig = SW'({1'b0, f} << sh);
            ex  = XW'(1) - XW'(sh);
        end
`endif
    endfunction

    logic                 s1, s2, nan1, nan2, snan1, snan2, inf1, inf2, zero1, zero2, a_lt_b;
    logic [EXP_W-1:0]     e1f, e2f;
    logic [MAN_W-1:0]     f1, f2;
    logic [XW-1:0]        ex1, ex2;
    logic [SW-1:0]        sig1, sig2;
    logic signed [XW-1:0] exp_d;
    logic [RW-1:0]        rem_d;
    logic                 spec_d, spec_inv_d, spec_dz_d;
    logic [W-1:0]         spec_res_d;

    assign s1  = a_op_q[W-1];
    assign s2  = b_op_q[W-1];
    assign e1f = a_op_q[W-2 -: EXP_W];
    assign e2f = b_op_q[W-2 -: EXP_W];
    assign f1  = a_op_q[MAN_W-1:0];
    assign f2  = b_op_q[MAN_W-1:0];

    // PRE: classify operands, pick the special result or prime the divider
    always_comb begin
        nan1  = (&e1f) & (|f1);
        nan2  = (&e2f) & (|f2);
        snan1 = nan1 & ~f1[MAN_W-1];
        snan2 = nan2 & ~f2[MAN_W-1];
        inf1  = (&e1f) & ~(|f1);
        inf2  = (&e2f) & ~(|f2);
`ifdef FP_DIV_SUBNORM_EN
        zero1 = ~(|e1f) & ~(|f1);
        zero2 = ~(|e2f) & ~(|f2);
`else
        zero1 = ~(|e1f);
        zero2 = ~(|e2f);
`endif
        norm(e1f, f1, ex1, sig1);
        norm(e2f, f2, ex2, sig2);
        a_lt_b = sig1 < sig2;
        exp_d  = ex1 - ex2 + BIAS - XW'(a_lt_b);
        rem_d  = a_lt_b ? {sig1, 1'b0} : {1'b0, sig1};

        spec_d     = 1'b1;
        spec_inv_d = 1'b0;
        spec_dz_d  = 1'b0;
        spec_res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        if (nan1 | nan2) begin
            spec_inv_d = snan1 | snan2;
        end else if ((zero1 & zero2) | (inf1 & inf2)) begin
            spec_inv_d = 1'b1;
        end else if (inf1) begin
            spec_res_d = {s1 ^ s2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (zero2) begin
            spec_res_d = {s1 ^ s2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_dz_d  = 1'b1;
        end else if (zero1 | inf2) begin
            spec_res_d = {s1 ^ s2, {(W-1){1'b0}}};
        end else begin
            spec_d = 1'b0;
        end
    end

    logic          div_ge;
    logic [RW-1:0] div_diff, rem_nxt;

    assign div_ge   = rem_q >= RW'(b_q);
    assign div_diff = div_ge ? rem_q - RW'(b_q) : rem_q;
    assign rem_nxt  = {div_diff[RW-2:0], 1'b0};

    logic                 tiny, rg, rr, rs, nx, inc;
    logic [SW-1:0]        rsig;
    logic [SW:0]          rsum;
    logic signed [XW-1:0] exp_r;
    logic [W-1:0]         res_d;
    logic                 ov_d, un_d, nx_d;
`ifdef FP_DIV_SUBNORM_EN
    logic [QW-1:0]        ext;
    int                   shamt;
`endif

    // RND: optional denormalisation, rounding, overflow/underflow resolution
    always_comb begin
        tiny = exp_q <= EXP_ZERO;
        rsig = quo_q[QW-1:2];
        rg   = quo_q[1];
        rr   = quo_q[0];
        rs   = sticky_q;
`ifdef FP_DIV_SUBNORM_EN
        ext   = quo_q;
        shamt = 0;
        if (tiny) begin
            shamt = 1 - int'(exp_q);
            if (shamt > int'(QW)) shamt = int'(QW);
            for (int i = 0; i < int'(QW); i++) begin
                if (i < shamt) rs = rs | ext[i];
            end
            ext  = ext >> shamt;
            rsig = ext[QW-1:2];
            rg   = ext[1];
            rr   = ext[0];
        end
`endif
        nx = rg | rr | rs;
        case (rm_q)
            RNE:     inc = rg & (rr | rs | rsig[0]);
            RNA:     inc = rg;
            RU:      inc = ~sign_q & nx;
            RD:      inc = sign_q & nx;
            default: inc = 1'b0;
        endcase
        rsum  = {1'b0, rsig} + (SW+1)'(inc);
        exp_r = tiny ? XW'(rsum[MAN_W]) : exp_q + XW'(rsum[SW]);

        res_d = {sign_q, exp_r[EXP_W-1:0], rsum[MAN_W-1:0]};
        ov_d  = 1'b0;
        un_d  = 1'b0;
        nx_d  = nx;
        if (exp_r >= EXP_MAX) begin
            ov_d = 1'b1;
            nx_d = 1'b1;
            if (rm_q == RNE || rm_q == RNA || (rm_q == RU && !sign_q) || (rm_q == RD && sign_q))
                res_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            else
                res_d = {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        end else if (tiny) begin
`ifdef FP_DIV_SUBNORM_EN
            un_d = nx;
`else
            res_d = {sign_q, {(W-1){1'b0}}};
            un_d  = 1'b1;
            nx_d  = 1'b1;
`endif
        end
    end

    // Control FSM and all registered state; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_op_q     <= '0;
            b_op_q     <= '0;
            rm_q       <= '0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            rem_q      <= '0;
            b_q        <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            spec_inv_q <= 1'b0;
            spec_dz_q  <= 1'b0;
            out_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ov_q       <= 1'b0;
            un_q       <= 1'b0;
            inv_q      <= 1'b0;
            dz_q       <= 1'b0;
            nx_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.act) begin
                        a_op_q  <= bus.in1;
                        b_op_q  <= bus.in2;
                        rm_q    <= bus.round_m;
                        state_q <= PRE;
                    end
                end
                PRE: begin
                    busy_q     <= 1'b1;
                    sign_q     <= s1 ^ s2;
                    exp_q      <= exp_d;
                    rem_q      <= rem_d;
                    b_q        <= sig2;
                    quo_q      <= '0;
                    cnt_q      <= '0;
                    spec_q     <= spec_d;
                    spec_res_q <= spec_res_d;
                    spec_inv_q <= spec_inv_d;
                    spec_dz_q  <= spec_dz_d;
                    state_q    <= spec_d ? RND : DIV;
                end
                DIV: begin
                    if (cnt_q == CW'(LAST)) begin
                        sticky_q <= |rem_q;
                        state_q  <= RND;
                    end else begin
                        rem_q <= rem_nxt;
                        quo_q <= {quo_q[QW-2:0], div_ge};
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RND: begin
                    if (spec_q) begin
                        out_q <= spec_res_q;
                        ov_q  <= 1'b0;
                        un_q  <= 1'b0;
                        inv_q <= spec_inv_q;
                        dz_q  <= spec_dz_q;
                        nx_q  <= 1'b0;
                    end else begin
                        out_q <= res_d;
                        ov_q  <= ov_d;
                        un_q  <= un_d;
                        inv_q <= 1'b0;
                        dz_q  <= 1'b0;
                        nx_q  <= nx_d;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out      = out_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.ov       = ov_q;
    assign bus.un       = un_q;
    assign bus.inv      = inv_q;
    assign bus.div_zero = dz_q;
    assign bus.inexact  = nx_q;
endmodule
